cnt_reg_ctrl: RTL and testbench
===============================

// Module: cnt_reg_ctrl
// PURPOSE
//  Register-interface slave for the simple counter peripheral. Consumes cnt_reg_pkg::reg_req_t and
//  returns cnt_reg_pkg::reg_rsp_t. Owns the control/status registers and the counter datapath.
//  Raises a level interrupt on terminal count. Sits directly behind the user-domain bus-to-reg bridge.
// PARAMETERS
//  CntWidth  32  counter/threshold width in bits, 1..32; upper rdata bits read 0
// PORTS
//  clk_i    in   1         system clock
//  rst_ni   in   1         asynchronous active-low reset
//  reg_req_i in  reg_req_t register request (addr, write, wdata, wstrb, valid)
//  reg_rsp_o out reg_rsp_t register response (rdata, error, ready)
//  irq_o    out  1         terminal-count interrupt, level, registered
// BEHAVIOUR
//  Reset: all registers 0; FSM IDLE; rsp.ready=0, rsp.error=0, rsp.rdata=0, irq_o=0.
//  Map (addr[4:0], word-aligned; addr[31:5] ignored):
//   0x00 CTRL   [0]EN rw, [1]CLR w1 (self-clears, reads 0), [2]IE rw
//   0x04 THRESH rw CntWidth; 0x08 VALUE rw (write loads counter); 0x0C STATUS [0]TC, write-1-clear
//  Handshake FSM, 2 states:
//   IDLE: valid=1 -> sample request, perform write/read decode, go RESP. ready=0.
//   RESP: ready=1 for exactly one cycle with registered rdata/error -> IDLE. Latency 1 cycle.
//   Requester holds valid and fields stable until ready; valid seen in IDLE after RESP = new request.
//  Writes honour wstrb per byte on rw registers; W1/W1C bits act only if their byte strobe set.
//  Error: addr[1:0]!=0 or addr[4:0] unmapped -> error=1, rdata=0, no side effect. Reads never
//   have side effects.
//  Counter, per cycle with EN=1 and tick=1: VALUE==THRESH -> VALUE=0, TC set; else VALUE+1.
//   THRESH=0 -> TC every tick. Arithmetic modulo 2^CntWidth; no other wrap path.
//  Priority same cycle: bus VALUE write > CLR > increment. CLR zeroes VALUE only, not TC.
//  TC set and TC W1C same cycle -> TC stays 1 (set wins). Write to VALUE==THRESH does not set TC.
//  irq_o = registered (TC & IE); follows TC/IE with one-cycle delay.
//  Async reset mid-transaction: FSM to IDLE, ready drops immediately, request lost.
// CONFIGURATION
//  CNT_PRESCALER_EN defined: adds 0x10 PRESC rw [15:0]; 16-bit prescale counter, tick=1 once per
//   PRESC+1 enabled cycles; prescaler reset on CLR, on PRESC write, and while EN=0.
//  Undefined: tick=1 every cycle; 0x10 is unmapped (error=1).
// STRUCTURE
//  cnt_reg_pkg: reg_req_t/reg_rsp_t (existing) plus register offset localparams
//   (CNT_CTRL_OFFS..CNT_PRESC_OFFS), CTRL bit indices, and the FSM state enum.
//  One sub-module: cnt_core (counter, threshold compare, TC generation, optional prescaler);
//   cnt_reg_ctrl keeps the FSM, decode and register file.
// TESTING
//  Reset: hold rst_ni=0 -> rsp.ready=0, irq_o=0; read all regs after release -> 0, error=0.
//  Handshake: write THRESH=5 -> ready high exactly 1 cycle, 1 cycle after valid; read back 5.
//  Count: THRESH=3, CTRL=0x5 -> VALUE 0,1,2,3,0; TC=1 after 4th tick; irq_o 1 cycle later;
//   W1C STATUS=1 -> irq_o drops.
//  Collisions: VALUE write 0x10 coincident with increment -> reads 0x10; W1C coincident with
//   wrap -> TC stays 1.
//  Errors: read 0x14 and addr 0x02 -> error=1, rdata=0, no register changes; wstrb=0x1 to THRESH
//   writes byte 0 only.
//  CNT_PRESCALER_EN: PRESC=2, THRESH=10 -> VALUE increments every 3 cycles; without macro, 0x10 -> error=1.

Source files
------------

// File: rtl/cnt_reg_pkg.sv
// Shared types, register map and FSM encoding for the counter peripheral register slave.
// Optional prescaler build: define CNT_PRESCALER_EN.
package cnt_reg_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;

    localparam logic [4:0] CNT_CTRL_OFFS   = 5'h00;
    localparam logic [4:0] CNT_THRESH_OFFS = 5'h04;
    localparam logic [4:0] CNT_VALUE_OFFS  = 5'h08;
    localparam logic [4:0] CNT_STATUS_OFFS = 5'h0C;
    localparam logic [4:0] CNT_PRESC_OFFS  = 5'h10;

    localparam int unsigned CNT_CTRL_EN_BIT  = 0;
    localparam int unsigned CNT_CTRL_CLR_BIT = 1;
    localparam int unsigned CNT_CTRL_IE_BIT  = 2;

    localparam logic [0:0] CNT_ST_IDLE = 1'b0;
    localparam logic [0:0] CNT_ST_RESP = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE = CNT_ST_IDLE,
        ST_RESP = CNT_ST_RESP
    } cnt_state_e;

    // Byte-lane merge: lanes with a strobe take the new data, the rest keep the old value.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_val[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/cnt_reg_if.sv
// Register request/response bundle between the bus-to-reg bridge (master) and the counter slave.
interface cnt_reg_if
    import cnt_reg_pkg::*;
();
    reg_req_t req;
    reg_rsp_t rsp;

    modport master (output req, input rsp);
    modport slave  (input req, output rsp);
endinterface

// File: rtl/cnt_core.sv
// Counter datapath: threshold compare, terminal-count flag and, with CNT_PRESCALER_EN, a tick prescaler.
module cnt_core #(
    parameter int unsigned CntWidth = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en,
    input  logic                clr,
    input  logic                value_we,
    input  logic [CntWidth-1:0] value_wdata,
    input  logic [CntWidth-1:0] thresh,
    input  logic                tc_clr,
`ifdef CNT_PRESCALER_EN
    input  logic [15:0]         presc,
    input  logic                presc_we,
`endif
    output logic [CntWidth-1:0] value,
    output logic                tc
);

    localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

    logic [CntWidth-1:0] value_r;
    logic                tc_r;
    logic                tick_s;
    logic                wrap_s;
    logic                tc_set_s;

`ifdef CNT_PRESCALER_EN
    logic [15:0] psc_r;

    assign tick_s = (psc_r == presc);

    // Prescale counter restarts on CLR, on a PRESC write and whenever counting is disabled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            psc_r <= 16'd0;
        end else if (!en || clr || presc_we || tick_s) begin
            psc_r <= 16'd0;
        end else begin
            psc_r <= psc_r + 16'd1;
        end
    end
`else
    assign tick_s = 1'b1;
`endif

    // A wrap only happens when the increment path is actually taken (bus write and CLR win).
    assign wrap_s   = en && tick_s && (value_r == thresh);
    assign tc_set_s = wrap_s && !value_we && !clr;

    // Counter value: bus load > CLR > increment/wrap.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            value_r <= '0;
        end else if (value_we) begin
            value_r <= value_wdata;
        end else if (clr) begin
            value_r <= '0;
        end else if (en && tick_s) begin
            value_r <= wrap_s ? '0 : value_r + CntOne;
        end else begin
            value_r <= value_r;
        end
    end

    // Terminal-count flag; a coincident set beats the W1C.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tc_r <= 1'b0;
        end else if (tc_set_s) begin
            tc_r <= 1'b1;
        end else if (tc_clr) begin
            tc_r <= 1'b0;
        end else begin
            tc_r <= tc_r;
        end
    end

    assign value = value_r;
    assign tc    = tc_r;

endmodule

// File: rtl/cnt_reg_ctrl.sv
// Counter peripheral register slave: handshake FSM, address decode and control registers.
// Optional PRESC register at 0x10 when CNT_PRESCALER_EN is defined.
module cnt_reg_ctrl
    import cnt_reg_pkg::*;
#(
    parameter int unsigned CntWidth = 32
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    cnt_reg_if.slave bus,
    output logic     irq_o
);

    reg_req_t            req_s;
    cnt_state_e          state_r;
    logic                ready_r, error_r, irq_r;
    logic [31:0]         rdata_r;
    logic                en_r, ie_r;
    logic [CntWidth-1:0] thresh_r;
    logic [CntWidth-1:0] value_s;
    logic                tc_s;
    logic [4:0]          offs_s;
    logic                err_s, wr_s;
    logic [31:0]         rd_data_s, thresh_ext_s, value_ext_s, thresh_merge_s, value_merge_s;
    logic                ctrl_we_s, thresh_we_s, value_we_s, status_we_s;
    logic                clr_s, tc_clr_s;
    logic                unused_s;

    assign req_s  = bus.req;
    assign offs_s = req_s.addr[4:0];

    // Zero-extend CntWidth registers to the 32-bit bus view.
    always_comb begin
        thresh_ext_s = 32'd0;
        value_ext_s  = 32'd0;
        thresh_ext_s[CntWidth-1:0] = thresh_r;
        value_ext_s[CntWidth-1:0]  = value_s;
    end

`ifdef CNT_PRESCALER_EN
    logic [15:0] presc_r;
    logic [31:0] presc_merge_s;
    logic        presc_we_s;
`endif

    // Address decode and read mux; misaligned or unmapped offsets flag an error and read 0.
    always_comb begin
        err_s     = 1'b0;
        rd_data_s = 32'd0;
        if (offs_s[1:0] != 2'b00) begin
            err_s = 1'b1;
        end else begin
            case (offs_s)
                CNT_CTRL_OFFS: begin
                    rd_data_s[CNT_CTRL_EN_BIT] = en_r;
                    rd_data_s[CNT_CTRL_IE_BIT] = ie_r;
                end
                CNT_THRESH_OFFS: rd_data_s = thresh_ext_s;
                CNT_VALUE_OFFS:  rd_data_s = value_ext_s;
                CNT_STATUS_OFFS: rd_data_s = {31'd0, tc_s};
`ifdef CNT_PRESCALER_EN
                CNT_PRESC_OFFS:  rd_data_s = {16'd0, presc_r};
`endif
                default:         err_s = 1'b1;
            endcase
        end
    end

    assign wr_s        = (state_r == ST_IDLE) && req_s.valid && req_s.write && !err_s;
    assign ctrl_we_s   = wr_s && (offs_s == CNT_CTRL_OFFS);
    assign thresh_we_s = wr_s && (offs_s == CNT_THRESH_OFFS);
    assign value_we_s  = wr_s && (offs_s == CNT_VALUE_OFFS);
    assign status_we_s = wr_s && (offs_s == CNT_STATUS_OFFS);
    assign clr_s       = ctrl_we_s && req_s.wstrb[0] && req_s.wdata[CNT_CTRL_CLR_BIT];
    assign tc_clr_s    = status_we_s && req_s.wstrb[0] && req_s.wdata[0];

    assign thresh_merge_s = apply_wstrb(thresh_ext_s, req_s.wdata, req_s.wstrb);
    assign value_merge_s  = apply_wstrb(value_ext_s, req_s.wdata, req_s.wstrb);

`ifdef CNT_PRESCALER_EN
    assign presc_we_s    = wr_s && (offs_s == CNT_PRESC_OFFS);
    assign presc_merge_s = apply_wstrb({16'd0, presc_r}, req_s.wdata, req_s.wstrb);
    assign unused_s      = ^{req_s.addr[31:5], thresh_merge_s, value_merge_s, presc_merge_s[31:16]};

    // Prescaler reload register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_r <= 16'd0;
        end else if (presc_we_s) begin
            presc_r <= presc_merge_s[15:0];
        end else begin
            presc_r <= presc_r;
        end
    end
`else
    assign unused_s = ^{req_s.addr[31:5], thresh_merge_s, value_merge_s};
`endif

    // CTRL and THRESH register file.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_r     <= 1'b0;
            ie_r     <= 1'b0;
            thresh_r <= '0;
        end else begin
            if (ctrl_we_s && req_s.wstrb[0]) begin
                en_r <= req_s.wdata[CNT_CTRL_EN_BIT];
                ie_r <= req_s.wdata[CNT_CTRL_IE_BIT];
            end else begin
                en_r <= en_r;
                ie_r <= ie_r;
            end
            if (thresh_we_s) begin
                thresh_r <= thresh_merge_s[CntWidth-1:0];
            end else begin
                thresh_r <= thresh_r;
            end
        end
    end

    // Handshake: accept in IDLE, present a one-cycle registered response in RESP.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b0;
            error_r <= 1'b0;
            rdata_r <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_s.valid) begin
                        state_r <= ST_RESP;
                        ready_r <= 1'b1;
                        error_r <= err_s;
                        rdata_r <= req_s.write ? 32'd0 : rd_data_s;
                    end else begin
                        state_r <= ST_IDLE;
                        ready_r <= 1'b0;
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    // Level interrupt, one cycle behind TC/IE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= tc_s && ie_r;
        end
    end

    cnt_core #(.CntWidth(CntWidth)) u_core (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .en          (en_r),
        .clr         (clr_s),
        .value_we    (value_we_s),
        .value_wdata (value_merge_s[CntWidth-1:0]),
        .thresh      (thresh_r),
        .tc_clr      (tc_clr_s),
`ifdef CNT_PRESCALER_EN
        .presc       (presc_r),
        .presc_we    (presc_we_s),
`endif
        .value       (value_s),
        .tc          (tc_s)
    );

    assign bus.rsp = '{rdata: rdata_r, error: error_r, ready: ready_r};
    assign irq_o   = irq_r;

endmodule

// File: tb/tb_cnt_reg_ctrl.sv
// Self-checking bench for cnt_reg_ctrl: directed steps plus random traffic against a register-level model.
module tb_cnt_reg_ctrl;
    import cnt_reg_pkg::*;

    localparam int unsigned W = 32;
    localparam longint unsigned MASK = (64'd1 << W) - 64'd1;
`ifdef CNT_PRESCALER_EN
    localparam bit HAS_PRESC = 1'b1;
`else
    localparam bit HAS_PRESC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic irq;
    int   n_checks = 0;
    int   n_fail = 0;

    cnt_reg_if bus_if();

    cnt_reg_ctrl #(.CntWidth(W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus_if),
        .irq_o  (irq)
    );

    always #5 clk = ~clk;

    // Model of the programmer-visible state.
    bit              m_en, m_ie, m_tc, m_irq;
    longint unsigned m_thresh, m_value;
    int unsigned     m_presc, m_psc;

    task automatic m_reset();
        m_en = 0; m_ie = 0; m_tc = 0; m_irq = 0;
        m_thresh = 0; m_value = 0; m_presc = 0; m_psc = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit m_err(input logic [31:0] a);
        logic [4:0] o;
        o = a[4:0];
        if (o[1:0] != 2'b00) return 1'b1;
        if (o == 5'h00 || o == 5'h04 || o == 5'h08 || o == 5'h0C) return 1'b0;
        if (o == 5'h10 && HAS_PRESC) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] o);
        case (o)
            5'h00:   return {29'd0, m_ie, 1'b0, m_en};
            5'h04:   return m_thresh[31:0];
            5'h08:   return m_value[31:0];
            5'h0C:   return {31'd0, m_tc};
            5'h10:   return m_presc;
            default: return 32'd0;
        endcase
    endfunction

    function automatic longint unsigned merge(input longint unsigned old, input logic [31:0] wd,
                                              input logic [3:0] st);
        logic [31:0] o;
        o = old[31:0];
        for (int b = 0; b < 4; b++) if (st[b]) o[8*b +: 8] = wd[8*b +: 8];
        return o;
    endfunction

    // Advance one clock; act/wr/a/wd/st describe a bus request accepted at this edge.
    task automatic step(input bit act, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] st);
        bit en_n = m_en, ie_n = m_ie, tc_n = m_tc, irq_n, clr = 0, w1c = 0, vw = 0, pw = 0, tick, set = 0;
        longint unsigned th_n = m_thresh, v_n = m_value, vnew = 0;
        int unsigned p_n = m_presc, psc_n;
        irq_n = m_tc & m_ie;
        if (act && wr && !m_err(a)) begin
            case (a[4:0])
                5'h00: if (st[0]) begin en_n = wd[0]; clr = wd[1]; ie_n = wd[2]; end
                5'h04: th_n = merge(m_thresh, wd, st) & MASK;
                5'h08: begin vw = 1; vnew = merge(m_value, wd, st) & MASK; end
                5'h0C: w1c = st[0] & wd[0];
                5'h10: begin pw = 1; p_n = merge(m_presc, wd, st) & 32'hFFFF; end
                default: ;
            endcase
        end
        tick = HAS_PRESC ? (m_psc == m_presc) : 1'b1;
        if (vw) v_n = vnew;
        else if (clr) v_n = 0;
        else if (m_en && tick) begin
            if (m_value == m_thresh) begin v_n = 0; set = 1; end
            else v_n = (m_value + 1) & MASK;
        end
        if (set) tc_n = 1;
        else if (w1c) tc_n = 0;
        psc_n = (!m_en || clr || pw || tick) ? 0 : m_psc + 1;
        @(posedge clk); #1;
        m_en = en_n; m_ie = ie_n; m_tc = tc_n; m_irq = irq_n;
        m_thresh = th_n; m_value = v_n; m_presc = p_n; m_psc = psc_n;
        chk("irq", {31'd0, irq}, {31'd0, m_irq});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 32'd0, 32'd0, 4'd0);
    endtask

    task automatic bus(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] st, output logic [31:0] rd);
        bit exp_err;
        logic [31:0] exp_rd;
        exp_err = m_err(a);
        exp_rd  = exp_err ? 32'd0 : m_read(a[4:0]);
        bus_if.req = '{addr: a, write: wr, wdata: wd, wstrb: st, valid: 1'b1};
        chk("ready_before", {31'd0, bus_if.rsp.ready}, 32'd0);
        step(1, wr, a, wd, st);
        chk("ready_resp", {31'd0, bus_if.rsp.ready}, 32'd1);
        chk("error", {31'd0, bus_if.rsp.error}, {31'd0, exp_err});
        if (!wr || exp_err) chk("rdata", bus_if.rsp.rdata, exp_rd);
        rd = bus_if.rsp.rdata;
        bus_if.req.valid = 1'b0;
        step(0, 0, 32'd0, 32'd0, 4'd0);
        chk("ready_drop", {31'd0, bus_if.rsp.ready}, 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        int          guard;
        int          offs [10] = '{0, 4, 8, 12, 16, 20, 24, 28, 2, 7};
        bus_if.req = '0;
        m_reset();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, bus_if.rsp.ready}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_error", {31'd0, bus_if.rsp.error}, 32'd0);
        rst_ni = 1'b1;
        idle(1);
        for (int i = 0; i < 4; i++) begin
            bus(0, 32'(4 * i), 32'd0, 4'd0, rd);
            chk("rst_reg", rd, 32'd0);
        end

        // Handshake and readback.
        bus(1, 32'h04, 32'd5, 4'hF, rd);
        bus(0, 32'h04, 32'd0, 4'h0, rd);
        chk("thresh_rb", rd, 32'd5);

        // Count to terminal, interrupt, clear.
        bus(1, 32'h04, 32'd3, 4'hF, rd);
        bus(1, 32'h00, 32'h5, 4'hF, rd);
        for (int i = 0; i < 4; i++) bus(0, 32'h08, 32'd0, 4'h0, rd);
        idle(3);
        bus(0, 32'h0C, 32'd0, 4'h0, rd);
        chk("tc_after_wrap", rd, 32'd1);
        bus(1, 32'h0C, 32'd1, 4'h1, rd);
        idle(2);

        // VALUE load coincident with increment.
        bus(1, 32'h08, 32'h10, 4'hF, rd);
        bus(0, 32'h08, 32'd0, 4'h0, rd);
        bus(1, 32'h08, 32'h0, 4'hF, rd);

        // W1C coincident with wrap.
        guard = 0;
        while (!(m_en && m_value == m_thresh) && guard < 20) begin idle(1); guard++; end
        chk("wrap_wait", {31'd0, (guard < 20)}, 32'd1);
        bus(1, 32'h0C, 32'd1, 4'h1, rd);
        bus(0, 32'h0C, 32'd0, 4'h0, rd);
        chk("tc_set_wins", rd, 32'd1);

        // Error accesses and byte strobes.
        bus(1, 32'h00, 32'h0, 4'hF, rd);
        bus(0, 32'h14, 32'd0, 4'h0, rd);
        bus(0, 32'h02, 32'd0, 4'h0, rd);
        bus(1, 32'h02, 32'hFFFF_FFFF, 4'hF, rd);
        bus(1, 32'h10, 32'd2, 4'hF, rd);
        bus(0, 32'h00, 32'd0, 4'h0, rd);
        chk("ctrl_untouched", rd, 32'd0);
        bus(1, 32'h04, 32'hAABB_CCDD, 4'h1, rd);
        bus(0, 32'h04, 32'd0, 4'h0, rd);
        chk("thresh_byte0", rd, 32'h0000_00DD);

`ifdef CNT_PRESCALER_EN
        bus(1, 32'h10, 32'd2, 4'hF, rd);
        bus(1, 32'h04, 32'd10, 4'hF, rd);
        bus(1, 32'h08, 32'd0, 4'hF, rd);
        bus(1, 32'h00, 32'h1, 4'hF, rd);
        idle(9);
        bus(0, 32'h08, 32'd0, 4'h0, rd);
        bus(1, 32'h00, 32'h2, 4'hF, rd);
`endif

        // Random traffic.
        for (int n = 0; n < 250; n++) begin
            int    o;
            bit    wr;
            logic [31:0] a, wd;
            o  = offs[$urandom_range(0, 9)];
            wr = $urandom_range(0, 1);
            a  = ($urandom() & 32'hFFFF_FFE0) | 32'(o);
            case (o)
                0:       wd = $urandom_range(0, 7);
                4, 8:    wd = $urandom_range(0, 6);
                12:      wd = $urandom_range(0, 1);
                16:      wd = $urandom_range(0, 3);
                default: wd = $urandom();
            endcase
            bus(wr, a, wd, 4'($urandom_range(0, 15)), rd);
            idle($urandom_range(0, 3));
        end

        // Asynchronous reset while a response is pending.
        bus_if.req = '{addr: 32'h04, write: 1'b0, wdata: 32'd0, wstrb: 4'h0, valid: 1'b1};
        step(1, 0, 32'h04, 32'd0, 4'h0);
        chk("pre_reset_ready", {31'd0, bus_if.rsp.ready}, 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        chk("async_ready", {31'd0, bus_if.rsp.ready}, 32'd0);
        chk("async_irq", {31'd0, irq}, 32'd0);
        bus_if.req.valid = 1'b0;
        m_reset();
        @(posedge clk); #1;
        rst_ni = 1'b1;
        idle(1);
        bus(0, 32'h00, 32'd0, 4'h0, rd);
        chk("post_reset_ctrl", rd, 32'd0);
        bus(0, 32'h04, 32'd0, 4'h0, rd);
        chk("post_reset_thresh", rd, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
